// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and the packed stage payload layout
// for the EX->MEM / MEM->WB pipeline registers.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int RN_W   = 5;
  localparam int CTRL_W = 3;

  localparam int CTRL_WREG  = 0;
  localparam int CTRL_M2REG = 1;
  localparam int CTRL_WMEM  = 2;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] b;
    logic [RN_W-1:0]   rn;
  } stage_payload_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with a registered in_ready (no out_ready->in_ready
// combinational path) and a flush that empties both entries.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_v, skid_v, rdy_q;
  logic [W-1:0] main_d, skid_d;
  logic         accept, advance;

  assign accept    = in_valid && rdy_q && !flush;
  assign advance   = !main_v || out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = main_v;
  assign out_data  = main_d;

  // rdy_q always tracks !skid_v, so a beat never arrives while skid is full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (advance) begin
      if (skid_v) begin
        main_v <= 1'b1;
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else begin
        main_v <= accept;
        if (accept) main_d <= in_data;
      end
      rdy_q <= 1'b1;
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
      rdy_q  <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_em_stage.sv
// EX->MEM pipeline register with valid/ready, flush, bubble ctrl gating and a
// saturating stall counter. Define PIPE_EM_SKID_EN for the 2-entry skid build.
module pipe_em_stage #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int RN_W    = pipe_pkg::RN_W,
  parameter int CTRL_W  = pipe_pkg::CTRL_W,
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [RN_W-1:0]    in_rn,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_alu,
  output logic [DATA_W-1:0]  out_b,
  output logic [RN_W-1:0]    out_rn,
  output logic [STALL_W-1:0] stall_cnt
);
  import pipe_pkg::*;

  localparam int PW = CTRL_W + 2*DATA_W + RN_W;

  logic [PW-1:0]     in_pl, out_pl;
  logic              q_valid;
  logic [CTRL_W-1:0] ctrl_q;

  assign in_pl = {in_ctrl, in_alu, in_b, in_rn};

`ifdef PIPE_EM_SKID_EN
  pipe_skid_buf #(.W(PW)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (q_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );
`else
  logic [PW-1:0] pl_q;

  assign in_ready = !q_valid || out_ready;
  assign out_pl   = pl_q;

  // Flush outranks accept; payload only moves on accept so stalls hold it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      pl_q    <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      q_valid <= 1'b1;
      pl_q    <= in_pl;
    end else if (out_ready) begin
      q_valid <= 1'b0;
    end
  end
`endif

  assign out_valid = q_valid;
  assign {ctrl_q, out_alu, out_b, out_rn} = out_pl;
  // A bubble must never assert wreg/m2reg/wmem downstream.
  assign out_ctrl = ctrl_q & {CTRL_W{q_valid}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (q_valid && !out_ready && stall_cnt != {STALL_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
